// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier
// and restoring divider with valid/ready request and response ports.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam logic [5:0] OP_MUL    = 6'b100111;
    localparam logic [5:0] OP_MULH   = 6'b101000;
    localparam logic [5:0] OP_MULHU  = 6'b101001;
    localparam logic [5:0] OP_MULHSU = 6'b101010;
    localparam logic [5:0] OP_DIV    = 6'b101011;
    localparam logic [5:0] OP_DIVU   = 6'b101100;
    localparam logic [5:0] OP_REM    = 6'b101101;
    localparam logic [5:0] OP_REMU   = 6'b101110;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              sign_q, sign_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic              bad_q, bad_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_result_q, resp_result_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic              busy_q, busy_d;

    logic              acc_mul, acc_div, acc_sa, acc_sb, acc_sign;
    logic              op_is_mul;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, a_s;
    logic [XLEN-1:0]   fix_res;

    // Request decode: which operands are signed and the result sign rule.
    always_comb begin
        acc_mul  = 1'b0;
        acc_div  = 1'b0;
        acc_sa   = 1'b0;
        acc_sb   = 1'b0;
        acc_sign = 1'b0;
        case (req_op)
            OP_MUL, OP_MULH: begin
                acc_mul  = 1'b1;
                acc_sa   = 1'b1;
                acc_sb   = 1'b1;
                acc_sign = req_a[XLEN-1] ^ req_b[XLEN-1];
            end
            OP_MULHU: acc_mul = 1'b1;
            OP_MULHSU: begin
                acc_mul  = 1'b1;
                acc_sa   = 1'b1;
                acc_sign = req_a[XLEN-1];
            end
            OP_DIV: begin
                acc_div  = 1'b1;
                acc_sa   = 1'b1;
                acc_sb   = 1'b1;
                acc_sign = req_a[XLEN-1] ^ req_b[XLEN-1];
            end
            OP_REM: begin
                acc_div  = 1'b1;
                acc_sa   = 1'b1;
                acc_sb   = 1'b1;
                acc_sign = req_a[XLEN-1];
            end
            OP_DIVU, OP_REMU: acc_div = 1'b1;
            default: ;
        endcase
    end

    assign op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                       (op_q == OP_MULHU) || (op_q == OP_MULHSU);

    // Result selection and sign correction, used in FIX.
    always_comb begin
        prod_s  = sign_q ? -prod_q : prod_q;
        quot_s  = sign_q ? -quot_q : quot_q;
        rem_s   = sign_q ? -rem_q : rem_q;
        a_s     = sign_q ? -mag_a_q : mag_a_q;
        fix_res = '0;
        case (op_q)
            OP_MUL: fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU:
                fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (dz_q)       fix_res = '1;
                else if (ovf_q) fix_res = MIN_INT;
                else            fix_res = quot_s;
            end
            OP_REM, OP_REMU: begin
                if (dz_q)       fix_res = a_s;
                else if (ovf_q) fix_res = '0;
                else            fix_res = rem_s;
            end
            default: fix_res = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        tag_d         = tag_q;
        mag_a_d       = mag_a_q;
        mag_b_d       = mag_b_q;
        sign_d        = sign_q;
        dz_d          = dz_q;
        ovf_d         = ovf_q;
        bad_d         = bad_q;
        cnt_d         = cnt_q;
        prod_d        = prod_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_tag_d    = resp_tag_q;
        mul_sum       = '0;
        div_shift     = '0;
        div_diff      = '0;
        req_ready     = (state_q == S_IDLE) && !flush;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    tag_d   = req_tag;
                    sign_d  = acc_sign;
                    mag_a_d = (acc_sa && req_a[XLEN-1]) ? -req_a : req_a;
                    mag_b_d = (acc_sb && req_b[XLEN-1]) ? -req_b : req_b;
                    dz_d    = acc_div && (req_b == '0);
                    ovf_d   = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                              (req_a == MIN_INT) && (req_b == '1);
                    bad_d   = !(acc_mul || acc_div);
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d   = 5'd31;
                prod_d  = {{XLEN{1'b0}}, mag_b_q};
                rem_d   = '0;
                quot_d  = mag_a_q;
                state_d = (dz_q || ovf_q || bad_q) ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (op_is_mul) begin
                    // Multiplier sits in the low half and shifts out LSB-first.
                    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                              (prod_q[0] ? {1'b0, mag_a_q} : '0);
                    prod_d  = {mul_sum, prod_q[XLEN-1:1]};
                end else begin
                    div_shift = {rem_q, quot_q[XLEN-1]};
                    div_diff  = div_shift - {1'b0, mag_b_q};
                    if (div_shift >= {1'b0, mag_b_q}) begin
                        rem_d  = div_diff[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d  = div_shift[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = S_FIX;
            end
            S_FIX: begin
                resp_result_d = fix_res;
                resp_tag_d    = tag_q;
                resp_valid_d  = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            tag_q         <= '0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            sign_q        <= 1'b0;
            dz_q          <= 1'b0;
            ovf_q         <= 1'b0;
            bad_q         <= 1'b0;
            cnt_q         <= '0;
            prod_q        <= '0;
            rem_q         <= '0;
            quot_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_tag_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
            mag_a_q       <= mag_a_d;
            mag_b_q       <= mag_b_d;
            sign_q        <= sign_d;
            dz_q          <= dz_d;
            ovf_q         <= ovf_d;
            bad_q         <= bad_d;
            cnt_q         <= cnt_d;
            prod_q        <= prod_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_tag_q    <= resp_tag_d;
            busy_q        <= busy_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_tag    = resp_tag_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table,
// multi-cycle corner sequences and randomized ops against an arithmetic model.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M arithmetic definitions.
    function automatic logic [31:0] model(input logic [5:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned pu;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            6'h27: begin p = sa * sb; return p[31:0]; end
            6'h28: begin p = sa * sb; return p[63:32]; end
            6'h29: begin pu = ua * ub; return pu[63:32]; end
            6'h2A: begin p = sa * longint'(ub); return p[63:32]; end
            6'h2B: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            6'h2C: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub;
                return pu[31:0];
            end
            6'h2D: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            6'h2E: begin
                if (b == 0) return a;
                pu = ua % ub;
                return pu[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [5:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (op < 6'h27 || op > 6'h2E) return 2;
        if (op >= 6'h2B && b == 0) return 2;
        if ((op == 6'h2B || op == 6'h2D) &&
            a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        end
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic await_resp(input string name, input int lat,
                              input logic [31:0] res, input logic [4:0] tag);
        int n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                n = i;
                break;
            end
        end
        chk({name, "_lat"}, n, lat);
        if (n != 0) begin
            chk({name, "_res"}, resp_result, res);
            chk({name, "_tag"}, {27'd0, resp_tag}, {27'd0, tag});
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            chk({name, "_drop"}, {31'd0, resp_valid}, 32'd0);
            chk({name, "_rdy"}, {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [5:0]  ops[10];
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tg;
        int          seen;

        vecs[0]  = '{6'h27, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{6'h28, 32'h8000_0000, 32'h8000_0000, 5'd2,
                     32'h4000_0000, 34};
        vecs[2]  = '{6'h29, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
                     32'hFFFF_FFFE, 34};
        vecs[3]  = '{6'h2A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,
                     32'hFFFF_FFFF, 34};
        vecs[4]  = '{6'h2B, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{6'h2D, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{6'h2C, 32'd100, 32'd7, 5'd7, 32'd14, 34};
        vecs[7]  = '{6'h2E, 32'd100, 32'd7, 5'd8, 32'd2, 34};
        vecs[8]  = '{6'h2B, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2};
        vecs[9]  = '{6'h2E, 32'd5, 32'd0, 5'd10, 32'd5, 2};
        vecs[10] = '{6'h2B, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
                     32'h8000_0000, 2};
        vecs[11] = '{6'h2D, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 2};
        vecs[12] = '{6'h3F, 32'd5, 32'd3, 5'd13, 32'd0, 2};
        vecs[13] = '{6'h2D, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFF9, 2};

        ops = '{6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B,
                6'h2C, 6'h2D, 6'h2E, 6'h00, 6'h3F};

        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_tag", {27'd0, resp_tag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            await_resp($sformatf("vec%0d", i), vecs[i].lat,
                       vecs[i].exp, vecs[i].tag);
        end

        // Back-pressure: result and tag must hold while writeback stalls.
        issue(6'h2C, 32'd100, 32'd7, 5'h13);
        seen = 0;
        for (int i = 0; i < 60 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", {31'd0, resp_valid}, 32'd1);
        req_valid = 1'b1;
        req_op    = 6'h27;
        req_a     = 32'd9;
        req_b     = 32'd9;
        req_tag   = 5'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_result !== 32'd14 ||
                resp_tag !== 5'h13 || req_ready !== 1'b0) seen++;
        end
        chk("bp_stable_cycles", seen, 0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_release_busy", {31'd0, busy}, 32'd0);

        // Flush on cycle 10 of CALC; a request held during flush is refused.
        issue(6'h2C, 32'hDEAD_BEEF, 32'd3, 5'd20);
        repeat (10) @(posedge clk);
        #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 6'h27;
        req_a     = 32'd1;
        req_b     = 32'd1;
        req_tag   = 5'd21;
        #1;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, resp_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (resp_valid || busy) seen++;
        end
        chk("flush_no_resp", seen, 0);
        issue(6'h27, 32'd3, 32'd4, 5'd22);
        await_resp("post_flush_mul", 34, 32'd12, 5'd22);

        // Flush in DONE discards the result even with resp_ready high.
        issue(6'h2B, 32'd5, 32'd0, 5'd23);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("done_flush_pre", {31'd0, resp_valid}, 32'd1);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        chk("done_flush_valid", {31'd0, resp_valid}, 32'd0);
        chk("done_flush_busy", {31'd0, busy}, 32'd0);

        // Async reset mid-CALC, then acceptance on the first edge after release.
        issue(6'h29, 32'h1234_5678, 32'h9ABC_DEF0, 5'd24);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", resp_result, 32'd0);
        chk("arst_tag", {27'd0, resp_tag}, 32'd0);
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        req_op    = 6'h27;
        req_a     = 32'd6;
        req_b     = 32'd7;
        req_tag   = 5'd25;
        req_valid = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("arst_accept", {31'd0, busy}, 32'd1);
        await_resp("arst_mul", 34, 32'd42, 5'd25);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            b  = $urandom;
            tg = 5'($urandom);
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            if (op == 6'h00 && i % 2 == 0) op = ops[i % 8];
            issue(op, a, b, tg);
            await_resp($sformatf("rnd%0d_op%h", i, op), model_lat(op, a, b),
                       model(op, a, b), tg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative multiply/divide unit for the RV32M opcodes of the ALU opcode space (6'b100111..6'b101110).
- Replaces single-cycle combinational loops with a 32-iteration shift-add multiplier and restoring divider.
- Sits beside the ALU in EX. Valid/ready request from issue, valid/ready response to writeback, flush input from the hazard/branch unit.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 5, destination-register tag width carried request to response

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  abort current operation, synchronous
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE with flush low
- req_op  in  6  ALU opcode: 100111 MUL, 101000 MULH, 101001 MULHU, 101010 MULHSU, 101011 DIV, 101100 DIVU, 101101 REM, 101110 REMU
- req_a  in  XLEN  operand A (rs1)
- req_b  in  XLEN  operand B (rs2)
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_result  out  XLEN  result
- resp_tag  out  TAG_W  tag of the accepted request
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE
  - resp_valid=0, resp_result=0, resp_tag=0, busy=0
  - internal counter, product, remainder and quotient registers cleared.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE -> PREP: req_valid&&req_ready at edge T. The edge latches op, tag, operand magnitudes, and result sign flags:
  - MUL/MULH: sign = a[31]^b[31]
  - MULHSU: sign = a[31]
  - DIV: sign = a[31]^b[31]
  - REM: sign = a[31]
  - unsigned ops: sign = 0.
- PREP, one cycle, clears the accumulators and sets counter=31.
  - Special case (divide op with b==0, or DIV/REM with a==0x80000000 and b==0xFFFFFFFF) goes PREP->FIX and skips CALC.
  - Otherwise goes PREP->CALC.
- CALC runs exactly 32 cycles.
  - Multiply: each cycle, if multiplier LSB is set, add the multiplicand into the upper half of the 64-bit product; then shift right 1 (33-bit add keeps the carry).
  - Divide: each cycle, shift the 33-bit partial remainder left and bring in the next dividend MSB. If remainder >= divisor, subtract and set the quotient bit.
  - At counter==0, go CALC->FIX.
- FIX, one cycle, selects and sign-corrects the result into resp_result. Two's-complement negate when the sign flag is set.
  - MUL: product[31:0]
  - MULH/MULHU/MULHSU: product[63:32], negation applied on the full 64 bits first
  - DIV/DIVU: quotient
  - REM/REMU: remainder
  - Divide by zero: quotient=0xFFFFFFFF, remainder=a (original signed value)
  - Signed overflow: quotient=0x80000000, remainder=0
- FIX -> DONE. resp_valid=1 from edge T+34 (normal path) or T+2 (special path).
- DONE holds resp_valid, resp_result and resp_tag stable until resp_ready. At the edge with resp_valid&&resp_ready: DONE->IDLE, resp_valid=0.
  - No new request is accepted in DONE; minimum request spacing is therefore 35 cycles, or 3 on the special path.
- Any opcode outside the table is accepted, takes the special path, and returns result 0.
- flush has priority over everything:
  - Any state goes to IDLE at the next edge; resp_valid=0 from that edge and no response is produced.
  - A request presented while flush is high is not accepted.
  - A flush in DONE discards the pending result even if resp_ready is high on the same edge.
- rst_n low mid-operation discards the operation immediately. With req_valid high, the first acceptance is the first edge after rst_n deasserts.
- busy is a registered decode of state. req_ready = (state==IDLE) && !flush.

Test Plan:
- Multiply: each request gets resp_valid exactly 34 cycles after acceptance.
  - MUL a=7, b=0xFFFFFFFD -> 0xFFFFFFEB
  - MULH 0x80000000×0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF
  - DIVU 100/7 -> 14; REMU 100/7 -> 2
- Special path, each with resp_valid 2 cycles after acceptance:
  - DIV 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM of the same operands -> 0
- Back-pressure and tag: hold resp_ready=0 for 10 cycles in DONE.
  - resp_result and resp_tag (tag=0x13) stay stable and req_ready stays 0.
  - Raising resp_ready returns to IDLE next edge; req_ready=1.
- Flush during CALC (cycle 10 of a DIVU): next edge busy=0, no resp_valid ever. A following MUL 3×4 returns 12 with its own tag.
- Assert rst_n=0 asynchronously mid-CALC: outputs go to reset values without a clock edge. After release, a fresh MUL 6×7 returns 42.
